// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel, W-bit round-robin arbitrating multiplexer with a
// one-entry registered output stage (valid/ready on every side).
// Build option: define RR_MUX_ARB_FIXED_PRIO_EN to replace the round-robin
// pointer with fixed priority (channel 0 highest).
module rr_mux_arb #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_sel
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  data_q;
  logic [SW-1:0] sel_q;
  logic [N-1:0]  cand;
  logic [N-1:0]  grant;
  logic [SW-1:0] gnt_idx;
  logic          gnt_any;
  logic [W-1:0]  gnt_data;
  logic          load;
  logic          accept;

  assign load   = (state_q == StEmpty) | out_ready;
  assign accept = load & gnt_any;

`ifdef RR_MUX_ARB_FIXED_PRIO_EN
  // Fixed priority: search candidates are simply the valid channels.
  always_comb begin
    cand = in_valid;
  end
`else
  logic [SW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  hi_mask;
  logic [N-1:0]  hi_valid;

  // Rotate the search: prefer valid channels at or above ptr, else wrap to the lowest.
  always_comb begin
    hi_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hi_mask[i] = (SW'(i) >= ptr_q);
    end
    hi_valid = in_valid & hi_mask;
    cand     = (|hi_valid) ? hi_valid : in_valid;
  end

  // Pointer moves past the accepted channel; wrap uses N, not 2**SW.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Lowest-index candidate wins; only the winner's data is muxed so X elsewhere is ignored.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    gnt_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i] && !gnt_any) begin
        grant[i] = 1'b1;
        gnt_idx  = SW'(i);
        gnt_any  = 1'b1;
        gnt_data = in_data[i*W +: W];
      end
    end
  end

  // Ready only while the stage can load; held low throughout reset.
  always_comb begin
    in_ready = grant & {N{load & rst_n}};
  end

  // Output stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Output stage next state: fill on grant, drain when consumer takes the word without refill.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (gnt_any) state_d = StFull;
      StFull:  if (out_ready) state_d = gnt_any ? StFull : StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // Payload register: captures the winner on every accept, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      sel_q  <= '0;
    end else if (accept) begin
      data_q <= gnt_data;
      sel_q  <= gnt_idx;
    end
  end

  // Output decode.
  always_comb begin
    out_valid = (state_q == StFull);
    out_data  = data_q;
    out_sel   = sel_q;
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Testbench for rr_mux_arb: directed scenarios plus a randomized run checked
// against a behavioural round-robin model. Honours RR_MUX_ARB_FIXED_PRIO_EN.
module tb_rr_mux_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 2;
`ifdef RR_MUX_ARB_FIXED_PRIO_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [SW-1:0]  out_sel;

  logic [3*W-1:0] in_data3 = '0;
  logic [2:0]     in_valid3 = '0;
  logic [2:0]     in_ready3;
  logic [W-1:0]   out_data3;
  logic           out_valid3;
  logic           out_ready3 = 1'b0;
  logic [1:0]     out_sel3;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int           m_ptr;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_win;
  bit           m_load;
  logic [N-1:0] m_ready;

  rr_mux_arb #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  rr_mux_arb #(.N(3), .W(W)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_sel   (out_sel3)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_sel = 0;
  endfunction

  // Combinational view of the current cycle: who wins and whether it is taken.
  function automatic void model_eval();
    int start;
    start  = Fixed ? 0 : m_ptr;
    m_load = !m_valid || out_ready;
    m_win  = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (in_valid[c] && m_win < 0) m_win = c;
    end
    m_ready = (m_load && m_win >= 0) ? (N'(1) << m_win) : '0;
  endfunction

  function automatic void model_clock();
    if (m_load) begin
      if (m_win >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[m_win*W +: W];
        m_sel   = m_win;
        m_ptr   = (m_win + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
  endfunction

  task automatic drive(input logic [N*W-1:0] d, input logic [N-1:0] v, input logic r);
    in_data = d; in_valid = v; out_ready = r;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic apply_reset();
    in_valid = '0; in_valid3 = '0; out_ready = 1'b0; out_ready3 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b1; in_data = {$urandom, $urandom};
    #1;
    n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_checks++; if (out_sel !== 2'd0) begin n_errors++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_hold_valid: got %b want 0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL release_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 4'b0001) begin n_errors++; $display("FAIL release_in_ready: got %b want 0001", in_ready); end
    in_valid = '0;
  endtask

  task automatic test_single();
    logic [N*W-1:0] d;
    apply_reset();
    d = {$urandom, $urandom};
    d[2*W +: W] = 8'hA5;
    drive(d, 4'b0100, 1'b1);
    n_checks++; if (in_ready !== 4'b0100) begin n_errors++; $display("FAIL single_in_ready: got %b want 0100", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data !== 8'hA5) begin n_errors++; $display("FAIL single_data: got %h want a5", out_data); end
    n_checks++; if (out_sel !== 2'd2) begin n_errors++; $display("FAIL single_sel: got %0d want 2", out_sel); end
    // Pointer now 3, so channel 3 wins when all are valid.
    drive(d, 4'b1111, 1'b1);
    n_checks++; if (in_ready !== (Fixed ? 4'b0001 : 4'b1000)) begin
      n_errors++; $display("FAIL single_ptr3: got %b want %b", in_ready, Fixed ? 4'b0001 : 4'b1000);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [N*W-1:0] d;
    int exp;
    apply_reset();
    d = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 8; i++) begin
      drive(d, 4'b1111, 1'b1);
      tick();
      exp = Fixed ? 0 : i % 4;
      n_checks++; if (out_valid !== 1'b1 || out_sel !== SW'(exp) || out_data !== W'(8'h10 + exp)) begin
        n_errors++; $display("FAIL rr_seq[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                             i, out_valid, out_sel, out_data, exp, 8'h10 + exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] d;
    logic [W-1:0]   hold_data;
    int             hold_sel;
    apply_reset();
    d = {8'h13, 8'h12, 8'h11, 8'h10};
    drive(d, 4'b1111, 1'b1); tick();
    drive(d, 4'b1111, 1'b1); tick();
    n_checks++; if (out_sel !== (Fixed ? 2'd0 : 2'd1)) begin n_errors++; $display("FAIL bp_pre_sel: got %0d want %0d", out_sel, Fixed ? 0 : 1); end
    hold_data = m_data; hold_sel = m_sel;
    for (int i = 0; i < 5; i++) begin
      drive(d, 4'b1111, 1'b0);
      n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, in_ready); end
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_sel !== SW'(hold_sel) || out_data !== hold_data) begin
        n_errors++; $display("FAIL bp_hold[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                             i, out_valid, out_sel, out_data, hold_sel, hold_data);
      end
    end
    drive(d, 4'b1111, 1'b1);
    n_checks++; if (in_ready !== (Fixed ? 4'b0001 : 4'b0100)) begin n_errors++; $display("FAIL bp_release_ready: got %b", in_ready); end
    tick();
    n_checks++; if (out_sel !== (Fixed ? 2'd0 : 2'd2) || out_data !== (Fixed ? 8'h10 : 8'h12)) begin
      n_errors++; $display("FAIL bp_next: got sel=%0d data=%h want sel=%0d", out_sel, out_data, Fixed ? 0 : 2);
    end
  endtask

  task automatic test_wrap3();
    int exp;
    apply_reset();
    in_data3 = {8'h22, 8'h21, 8'h20}; in_valid3 = 3'b101; out_ready3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = (Fixed || (i % 2 == 0)) ? 0 : 2;
      #1;
      n_checks++; if (in_ready3 !== (3'b001 << exp)) begin n_errors++; $display("FAIL wrap3_ready[%0d]: got %b want ch%0d", i, in_ready3, exp); end
      @(posedge clk); #1;
      n_checks++; if (out_valid3 !== 1'b1 || out_sel3 !== 2'(exp) || out_data3 !== W'(8'h20 + exp)) begin
        n_errors++; $display("FAIL wrap3_sel[%0d]: got sel=%0d data=%h want sel=%0d", i, out_sel3, out_data3, exp);
      end
    end
    in_valid3 = '0; out_ready3 = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [N*W-1:0] d;
    apply_reset();
    d = {$urandom, $urandom};
    drive(d, 4'b0100, 1'b1); tick();
    drive(d, 4'b1111, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL midrst_ready: got %b want 0000", in_ready); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(d, 4'b1010, 1'b1);
    n_checks++; if (in_ready !== 4'b0010) begin n_errors++; $display("FAIL midrst_first_ready: got %b want 0010", in_ready); end
    tick();
    n_checks++; if (out_sel !== 2'd1 || out_data !== d[W +: W]) begin
      n_errors++; $display("FAIL midrst_first: got sel=%0d data=%h want sel=1 data=%h", out_sel, out_data, d[W +: W]);
    end
  endtask

  task automatic test_random();
    logic [N*W-1:0] d;
    logic [N-1:0]   v;
    logic           r;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      v = N'($urandom);
      r = ($urandom % 4) != 0;
      for (int c = 0; c < N; c++) d[c*W +: W] = v[c] ? W'($urandom) : 'x;
      drive(d, v, r);
      n_checks++; if (in_ready !== m_ready) begin n_errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, m_ready); end
      tick();
      n_checks++; if (out_valid !== m_valid) begin n_errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, m_valid); end
      if (m_valid) begin
        n_checks++; if (out_data !== m_data || out_sel !== SW'(m_sel)) begin
          n_errors++; $display("FAIL rand_word[%0d]: got sel=%0d data=%h want sel=%0d data=%h",
                               i, out_sel, out_data, m_sel, m_data);
        end
      end
    end
    in_valid = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap3();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
